sample_sender: RTL
==================

// Module: sample_sender
// PURPOSE
//  Transmit side of the capture/readback path: on a start pulse from the main FSM, reads NUM_SAMPLES
//  words from the sample RAM and sends each over the serial line as UART 8N1 bytes, MS byte first.
//  Ends with a one-cycle done pulse back to the main FSM. The sample RAM is synchronous with
//  1-cycle read latency. The serial receiver is the counterpart on the host link.
// PARAMETERS
//  CLKS_PER_BIT  434  clock cycles per UART bit (e.g. 50 MHz / 115200 baud); must be >= 2
//  NUM_SAMPLES   256  number of RAM words sent per run; must be >= 1 and <= 2**ADDR_WIDTH
//  ADDR_WIDTH    8    sample RAM address width
//  DATA_WIDTH    16   sample word width; multiple of 8; sent as DATA_WIDTH/8 bytes
// PORTS
//  iClock        in   1           system clock, all logic on rising edge
//  iReset        in   1           synchronous, active-high reset
//  iStartSending in   1           one-cycle start pulse from main FSM
//  oMemAddr      out  ADDR_WIDTH  sample RAM read address
//  iMemData      in   DATA_WIDTH  sample RAM read data, valid 1 cycle after oMemAddr
//  oTx           out  1           UART serial output, idle high
//  oBusy         out  1           high from accept until done pulse (inclusive)
//  oSendingDone  out  1           one-cycle pulse after last stop bit of last sample
// BEHAVIOUR
//  Reset: oTx=1, oBusy=0, oSendingDone=0, oMemAddr=0, state IDLE, all counters/shift regs 0.
//  Reset mid-frame aborts immediately: oTx high on next edge, no done pulse, no partial resume.
//  All outputs registered.
//  States: IDLE -> SET_ADDR -> WAIT_DATA -> START_BIT -> DATA_BITS -> STOP_BIT -> (next byte:
//   START_BIT | next sample: SET_ADDR | last: DONE) -> IDLE.
//  IDLE: iStartSending=1 accepted; oMemAddr<=0, oBusy<=1. iStartSending ignored in any other state.
//  SET_ADDR: oMemAddr holds sample index for one cycle (RAM registers it).
//  WAIT_DATA: at end of cycle, capture iMemData into word register; byte index=DATA_WIDTH/8-1.
//  Latency: oTx falls exactly 3 cycles after the cycle iStartSending is sampled high.
//  START_BIT: oTx=0 for CLKS_PER_BIT cycles; load current byte into 8-bit shift register.
//  DATA_BITS: 8 bits LSB first, each CLKS_PER_BIT cycles; bit counter 0..7.
//  STOP_BIT: oTx=1 for CLKS_PER_BIT cycles.
//  Bytes of one sample are back-to-back (no idle between stop and next start).
//  Between samples: 2 idle-high cycles (SET_ADDR, WAIT_DATA) before next start bit.
//  Sample index increments after last byte of a sample; no wrap: last index NUM_SAMPLES-1,
//  then DONE. If NUM_SAMPLES=2**ADDR_WIDTH, index counter is ADDR_WIDTH+1 bits wide so
//  termination is exact.
//  DONE: oSendingDone=1 and oBusy=1 for one cycle, oTx=1; then IDLE, oBusy=0.
//  Start pulse in the DONE cycle is ignored; start in the first IDLE cycle after is accepted.
//  Baud counter: 0..CLKS_PER_BIT-1, reloads at each bit boundary; bit-time exact, no drift.
//  Run length: NUM_SAMPLES*(DATA_WIDTH/8)*10*CLKS_PER_BIT + 2*NUM_SAMPLES + 2 cycles,
//  from accept cycle to done pulse inclusive.
//  iMemData is sampled only in WAIT_DATA; changes at other times have no effect.
// TESTING (CLKS_PER_BIT=4, NUM_SAMPLES=4, ADDR_WIDTH=2, DATA_WIDTH=16 unless noted)
//  1 RAM={16'hA55A,16'h0001,16'h8000,16'hFFFF}, pulse start -> UART decoder reads
//    A5 5A 00 01 80 00 FF FF; oTx low 3 cycles after start; done pulse once, 1 cycle wide.
//  2 Same run -> total accept-to-done = 4*2*40+8+2 = 330 cycles; oBusy high throughout;
//    oMemAddr steps 0,1,2,3 with no other values during run.
//  3 Repeated start pulses during run at cycles 10,100,300 -> ignored; exactly 8 bytes,
//    one done pulse.
//  4 Assert iReset at cycle 150 (mid data bit) -> oTx=1, oBusy=0 next edge; no done;
//    new start after reset sends full sequence from address 0.
//  5 Start pulse in DONE cycle ignored; start the next cycle accepted -> second full run identical.
//  6 NUM_SAMPLES=4, ADDR_WIDTH=2, DATA_WIDTH=8, RAM={00,FF,3C,C3} -> bytes 00 FF 3C C3;
//    run = 4*40+8+2 = 170 cycles; no address wrap.

Source files
------------

// File: rtl/sample_sender.sv
// Reads NUM_SAMPLES words from a 1-cycle-latency sample RAM and sends each one
// as DATA_WIDTH/8 UART 8N1 bytes, most significant byte first, then pulses done.
module sample_sender #(
   parameter int CLKS_PER_BIT = 434,
   parameter int NUM_SAMPLES  = 256,
   parameter int ADDR_WIDTH   = 8,
   parameter int DATA_WIDTH   = 16
) (
   input  logic                  iClock,
   input  logic                  iReset,
   input  logic                  iStartSending,
   output logic [ADDR_WIDTH-1:0] oMemAddr,
   input  logic [DATA_WIDTH-1:0] iMemData,
   output logic                  oTx,
   output logic                  oBusy,
   output logic                  oSendingDone
);

   localparam int BYTES  = DATA_WIDTH / 8;
   localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W  = ADDR_WIDTH + 1;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_SAMPLES - 1);
   localparam logic [BIDX_W-1:0] BIDX_TOP  = BIDX_W'(BYTES - 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_SET_ADDR  = 3'd1;
   localparam logic [2:0] S_WAIT_DATA = 3'd2;
   localparam logic [2:0] S_START_BIT = 3'd3;
   localparam logic [2:0] S_DATA_BITS = 3'd4;
   localparam logic [2:0] S_STOP_BIT  = 3'd5;
   localparam logic [2:0] S_DONE      = 3'd6;

   logic [2:0]            state_reg;
   logic [BAUD_W-1:0]     baud_reg;
   logic [2:0]            bit_reg;
   logic [BIDX_W-1:0]     byte_idx_reg;
   logic [DATA_WIDTH-1:0] word_reg;
   logic [7:0]            shift_reg;
   logic [IDX_W-1:0]      sample_idx_reg;
   logic [ADDR_WIDTH-1:0] addr_reg;
   logic                  tx_reg;
   logic                  busy_reg;
   logic                  done_reg;

   // Byte view of the captured word, padded to a power of two so any index is legal.
   logic [7:0] byte_arr [2**BIDX_W];
   generate
      for (genvar gi = 0; gi < 2**BIDX_W; gi++) begin : g_bytes
         if (gi < BYTES) begin : g_real
            assign byte_arr[gi] = word_reg[gi*8 +: 8];
         end else begin : g_pad
            assign byte_arr[gi] = 8'h00;
         end
      end
   endgenerate

   logic [7:0]       cur_byte;
   logic [IDX_W-1:0] next_idx;
   logic             baud_end;

   assign cur_byte = byte_arr[byte_idx_reg];
   assign next_idx = sample_idx_reg + 1'b1;
   assign baud_end = (baud_reg == BAUD_LAST);

   always_ff @(posedge iClock) begin
      if (iReset) begin
         state_reg      <= S_IDLE;
         baud_reg       <= '0;
         bit_reg        <= '0;
         byte_idx_reg   <= '0;
         word_reg       <= '0;
         shift_reg      <= '0;
         sample_idx_reg <= '0;
         addr_reg       <= '0;
         tx_reg         <= 1'b1;
         busy_reg       <= 1'b0;
         done_reg       <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               tx_reg   <= 1'b1;
               busy_reg <= 1'b0;
               done_reg <= 1'b0;
               if (iStartSending) begin
                  state_reg      <= S_SET_ADDR;
                  addr_reg       <= '0;
                  sample_idx_reg <= '0;
                  busy_reg       <= 1'b1;
               end
            end
            S_SET_ADDR: begin
               state_reg <= S_WAIT_DATA;
            end
            S_WAIT_DATA: begin
               word_reg     <= iMemData;
               byte_idx_reg <= BIDX_TOP;
               baud_reg     <= '0;
               tx_reg       <= 1'b0;
               state_reg    <= S_START_BIT;
            end
            S_START_BIT: begin
               // The shift register is loaded during the start bit and its
               // first bit is presented at the start/data boundary.
               if (baud_end) begin
                  baud_reg  <= '0;
                  bit_reg   <= '0;
                  tx_reg    <= shift_reg[0];
                  shift_reg <= shift_reg >> 1;
                  state_reg <= S_DATA_BITS;
               end else begin
                  baud_reg  <= baud_reg + 1'b1;
                  shift_reg <= cur_byte;
               end
            end
            S_DATA_BITS: begin
               if (baud_end) begin
                  baud_reg <= '0;
                  if (bit_reg == 3'd7) begin
                     tx_reg    <= 1'b1;
                     state_reg <= S_STOP_BIT;
                  end else begin
                     bit_reg   <= bit_reg + 1'b1;
                     tx_reg    <= shift_reg[0];
                     shift_reg <= shift_reg >> 1;
                  end
               end else begin
                  baud_reg <= baud_reg + 1'b1;
               end
            end
            S_STOP_BIT: begin
               if (baud_end) begin
                  baud_reg <= '0;
                  if (byte_idx_reg != '0) begin
                     byte_idx_reg <= byte_idx_reg - 1'b1;
                     tx_reg       <= 1'b0;
                     state_reg    <= S_START_BIT;
                  end else if (sample_idx_reg == IDX_LAST) begin
                     done_reg  <= 1'b1;
                     state_reg <= S_DONE;
                  end else begin
                     sample_idx_reg <= next_idx;
                     addr_reg       <= next_idx[ADDR_WIDTH-1:0];
                     state_reg      <= S_SET_ADDR;
                  end
               end else begin
                  baud_reg <= baud_reg + 1'b1;
               end
            end
            S_DONE: begin
               done_reg  <= 1'b0;
               busy_reg  <= 1'b0;
               tx_reg    <= 1'b1;
               state_reg <= S_IDLE;
            end
            default: begin
               state_reg <= S_IDLE;
               tx_reg    <= 1'b1;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign oMemAddr     = addr_reg;
   assign oTx          = tx_reg;
   assign oBusy        = busy_reg;
   assign oSendingDone = done_reg;

endmodule
